// File: rtl/avalon_st_width_upsizer.sv
// Packs RATIO narrow Avalon-ST beats into one wide word; the output is registered one cycle after the completing beat.
// When the output register is full and not being drained, st_in_ready drops and the assembly register stops filling.
module avalon_st_width_upsizer #(
    parameter  int IN_WIDTH  = 128,
    parameter  int RATIO     = 2,
    parameter  int MSB_FIRST = 1,
    localparam int OUT_WIDTH = IN_WIDTH * RATIO,
    localparam int CNT_W     = $clog2(RATIO + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  st_in_data,
    input  logic                 st_in_valid,
    input  logic                 st_in_endofpacket,
    output logic                 st_in_ready,
    output logic [OUT_WIDTH-1:0] st_out_data,
    output logic                 st_out_valid,
    output logic                 st_out_endofpacket,
    output logic [CNT_W-1:0]     st_out_count,
    input  logic                 st_out_ready
);

    logic [CNT_W-1:0]     r_cnt;
    logic [OUT_WIDTH-1:0] r_asm;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0]     r_out_cnt;
    logic                 r_out_eop;
    logic                 r_out_full;

    logic                 w_accept;
    logic                 w_complete;
    logic                 w_handshake;
    logic [CNT_W-1:0]     w_slot;
    logic [OUT_WIDTH-1:0] w_merged;

    // Ready depends only on registered state, the downstream ready and reset.
    assign st_in_ready = !reset && (!r_out_full || st_out_ready);
    assign w_accept    = st_in_valid && st_in_ready;
    assign w_complete  = (r_cnt == CNT_W'(RATIO - 1)) || st_in_endofpacket;
    assign w_handshake = r_out_full && st_out_ready;
    assign w_slot      = (MSB_FIRST != 0) ? (CNT_W'(RATIO - 1) - r_cnt) : r_cnt;

    always_comb begin
        w_merged = r_asm;
        for (int k = 0; k < RATIO; k++) begin
            if (w_slot == CNT_W'(k)) begin
                w_merged[k*IN_WIDTH +: IN_WIDTH] = st_in_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_asm      <= '0;
            r_out_data <= '0;
            r_out_cnt  <= '0;
            r_out_eop  <= 1'b0;
            r_out_full <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_out_full <= 1'b0;
            end
            // A completing beat overrides the drain so a word handed off and a new word landing share one cycle.
            if (w_accept) begin
                if (w_complete) begin
                    r_out_data <= w_merged;
                    r_out_cnt  <= r_cnt + CNT_W'(1);
                    r_out_eop  <= st_in_endofpacket;
                    r_out_full <= 1'b1;
                    r_cnt      <= '0;
                    r_asm      <= '0;
                end else begin
                    r_asm <= w_merged;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign st_out_data        = r_out_data;
    assign st_out_valid       = r_out_full;
    assign st_out_endofpacket = r_out_eop;
    assign st_out_count       = r_out_cnt;

endmodule

// File: tb/tb_avalon_st_width_upsizer.sv
// Three upsizer configurations driven by directed and random vectors, checked against a beat-queue model each cycle.
module tb_avalon_st_width_upsizer;

    logic         clock;
    logic         reset;
    logic [127:0] idat [3];
    logic [2:0]   ivld;
    logic [2:0]   ieop;
    logic [2:0]   ordy;
    logic [2:0]   ir;
    logic [2:0]   ov;
    logic [2:0]   oe;
    logic [255:0] d0;
    logic [127:0] d1;
    logic [95:0]  d2;
    logic [1:0]   c0;
    logic [2:0]   c1;
    logic [1:0]   c2;
    logic [511:0] od [3];
    logic [2:0]   oc [3];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int ratio_c [3] = '{2, 4, 3};
    int msb_c   [3] = '{1, 0, 1};
    int w_c     [3] = '{128, 32, 32};

    // Model: beats of the word being built, and the word the DUT must currently be holding.
    logic [127:0] pb [3][4];
    int           pn [3];
    bit           ef [3];
    logic [511:0] ew_d [3];
    int           ew_c [3];
    bit           ew_e [3];
    int           hs_cnt [3];
    logic [2:0]   rdy_neg;
    bit           mon_er;

    avalon_st_width_upsizer u_r2 (
        .clock(clock), .reset(reset),
        .st_in_data(idat[0]), .st_in_valid(ivld[0]), .st_in_endofpacket(ieop[0]), .st_in_ready(ir[0]),
        .st_out_data(d0), .st_out_valid(ov[0]), .st_out_endofpacket(oe[0]), .st_out_count(c0),
        .st_out_ready(ordy[0])
    );

    avalon_st_width_upsizer #(.IN_WIDTH(32), .RATIO(4), .MSB_FIRST(0)) u_r4 (
        .clock(clock), .reset(reset),
        .st_in_data(idat[1][31:0]), .st_in_valid(ivld[1]), .st_in_endofpacket(ieop[1]), .st_in_ready(ir[1]),
        .st_out_data(d1), .st_out_valid(ov[1]), .st_out_endofpacket(oe[1]), .st_out_count(c1),
        .st_out_ready(ordy[1])
    );

    avalon_st_width_upsizer #(.IN_WIDTH(32), .RATIO(3), .MSB_FIRST(1)) u_r3 (
        .clock(clock), .reset(reset),
        .st_in_data(idat[2][31:0]), .st_in_valid(ivld[2]), .st_in_endofpacket(ieop[2]), .st_in_ready(ir[2]),
        .st_out_data(d2), .st_out_valid(ov[2]), .st_out_endofpacket(oe[2]), .st_out_count(c2),
        .st_out_ready(ordy[2])
    );

    assign od[0] = {256'd0, d0};
    assign od[1] = {384'd0, d1};
    assign od[2] = {416'd0, d2};
    assign oc[0] = {1'b0, c0};
    assign oc[1] = c1;
    assign oc[2] = {1'b0, c2};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [511:0] build(input int k);
        logic [511:0] w;
        logic [511:0] m;
        int s;
        w = '0;
        m = (512'd1 << w_c[k]) - 512'd1;
        for (int j = 0; j < pn[k]; j++) begin
            s = (msb_c[k] != 0) ? (ratio_c[k] - 1 - j) : j;
            w = w | (({384'd0, pb[k][j]} & m) << (s * w_c[k]));
        end
        return w;
    endfunction

    // Compare process: everything the DUT shows at each falling edge is checked against the model.
    initial forever begin
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                check("rst_in_ready", ir[k], 0);
                check("rst_out_valid", ov[k], 0);
                check("rst_out_data", od[k], 0);
                check("rst_out_count", oc[k], 0);
                check("rst_out_eop", oe[k], 0);
                pn[k] = 0;
                ef[k] = 1'b0;
                rdy_neg[k] = 1'b0;
            end else begin
                mon_er = !ef[k] || ordy[k];
                check("out_valid", ov[k], ef[k]);
                check("in_ready", ir[k], mon_er);
                if (ef[k]) begin
                    check("out_data", od[k], ew_d[k]);
                    check("out_count", oc[k], ew_c[k]);
                    check("out_eop", oe[k], ew_e[k]);
                    if (ordy[k]) begin
                        ef[k] = 1'b0;
                        hs_cnt[k] = hs_cnt[k] + 1;
                    end
                end
                if (ivld[k] && mon_er) begin
                    pb[k][pn[k]] = idat[k];
                    pn[k] = pn[k] + 1;
                    if (pn[k] == ratio_c[k] || ieop[k]) begin
                        ew_d[k] = build(k);
                        ew_c[k] = pn[k];
                        ew_e[k] = ieop[k];
                        ef[k]   = 1'b1;
                        pn[k]   = 0;
                    end
                end
                rdy_neg[k] = mon_er;
            end
        end
    end

    task automatic send(input int k, input logic [127:0] d, input logic e);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        idat[k] = d;
        ivld[k] = 1'b1;
        ieop[k] = e;
        while (!acc && n < 200) begin
            @(posedge clock);
            acc = rdy_neg[k];
            n = n + 1;
        end
        check("send_accepted", acc, 1);
        #1;
    endtask

    task automatic idle(input int k);
        ivld[k] = 1'b0;
        ieop[k] = 1'b0;
    endtask

    int t0, t1, h0;

    initial begin
        reset = 1'b1;
        ivld  = '0;
        ieop  = '0;
        ordy  = '0;
        for (int k = 0; k < 3; k++) begin
            idat[k] = '0;
            pn[k] = 0;
            ef[k] = 1'b0;
            hs_cnt[k] = 0;
        end
        rdy_neg = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // RATIO=2, MSB first: A lands in the upper half, visible the cycle after beat 2.
        ordy[0] = 1'b1;
        send(0, {16{8'hAA}}, 1'b0);
        send(0, {16{8'hBB}}, 1'b0);
        idle(0);
        @(negedge clock);
        check("t1_valid", ov[0], 1);
        check("t1_word", od[0], {256'd0, {16{8'hAA}}, {16{8'hBB}}});
        check("t1_count", oc[0], 2);
        check("t1_eop", oe[0], 0);

        // RATIO=4, LSB first, output stalled for 5 cycles with a beat waiting.
        @(posedge clock); #1;
        ordy[1] = 1'b0;
        for (int i = 1; i <= 4; i++) send(1, 128'(i), 1'b0);
        fork
            send(1, 128'd5, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clock);
                    check("t2_stall_word", od[1], {384'd0, 32'd4, 32'd3, 32'd2, 32'd1});
                    check("t2_stall_ready", ir[1], 0);
                end
                @(posedge clock); #1;
                ordy[1] = 1'b1;
            end
        join
        for (int i = 6; i <= 8; i++) send(1, 128'(i), 1'b0);
        idle(1);
        @(negedge clock);
        check("t2_next_word", od[1], {384'd0, 32'd8, 32'd7, 32'd6, 32'd5});

        // Early end of packet, then a fresh word, then single-beat packets back to back.
        @(posedge clock); #1;
        send(1, 128'd7, 1'b0);
        send(1, 128'd8, 1'b1);
        idle(1);
        @(negedge clock);
        check("t3_eop_word", od[1], {384'd0, 32'd0, 32'd0, 32'd8, 32'd7});
        check("t3_eop_count", oc[1], 2);
        check("t3_eop_flag", oe[1], 1);
        @(posedge clock); #1;
        for (int i = 9; i <= 12; i++) send(1, 128'(i), 1'b0);
        idle(1);
        @(negedge clock);
        check("t3_fresh_word", od[1], {384'd0, 32'd12, 32'd11, 32'd10, 32'd9});
        check("t3_fresh_eop", oe[1], 0);
        @(posedge clock); #1;
        h0 = hs_cnt[1];
        t0 = cyc;
        send(1, 128'h51, 1'b1);
        send(1, 128'h52, 1'b1);
        send(1, 128'h53, 1'b1);
        t1 = cyc;
        idle(1);
        @(negedge clock);
        check("t3_single_word", od[1], {384'd0, 32'd0, 32'd0, 32'd0, 32'h53});
        check("t3_single_count", oc[1], 1);
        check("t3_single_cycles", t1 - t0, 3);
        repeat (2) @(posedge clock); #1;
        check("t3_single_words", hs_cnt[1] - h0, 3);

        // Back-to-back streaming at RATIO=2.
        h0 = hs_cnt[0];
        t0 = cyc;
        for (int i = 0; i < 64; i++) send(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
        t1 = cyc;
        idle(0);
        repeat (3) @(posedge clock); #1;
        check("t4_cycles", t1 - t0, 64);
        check("t4_words", hs_cnt[0] - h0, 32);

        // Reset with a partial RATIO=4 word in flight.
        send(1, 128'h31, 1'b0);
        send(1, 128'h32, 1'b0);
        send(1, 128'h33, 1'b0);
        idle(1);
        @(posedge clock); #3;
        reset = 1'b1;
        repeat (2) @(posedge clock); #1;
        reset = 1'b0;
        h0 = hs_cnt[1];
        for (int i = 'h41; i <= 'h44; i++) send(1, 128'(i), 1'b0);
        idle(1);
        @(negedge clock);
        check("t5_word", od[1], {384'd0, 32'h44, 32'h43, 32'h42, 32'h41});
        repeat (3) @(posedge clock); #1;
        check("t5_words", hs_cnt[1] - h0, 1);

        // Random valid, ready and end-of-packet at RATIO=3.
        for (int i = 0; i < 400; i++) begin
            ivld[2] = 1'($urandom_range(0, 1));
            ordy[2] = 1'($urandom_range(0, 1));
            ieop[2] = ($urandom_range(0, 3) == 0);
            idat[2] = {96'd0, $urandom()};
            @(posedge clock); #1;
        end
        ordy[2] = 1'b1;
        send(2, 128'h77, 1'b1);
        idle(2);
        repeat (3) @(posedge clock); #1;
        for (int k = 0; k < 3; k++) begin
            check("end_pending_beats", pn[k], 0);
            check("end_word_held", ov[k], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_st_width_upsizer.md
# avalon_st_width_upsizer

Parametrised Avalon-ST width upsizer that packs RATIO consecutive IN_WIDTH-bit input beats into one IN_WIDTH*RATIO-bit output word. It supports selectable beat ordering and early packet termination: a partial word is flushed on end-of-packet, zero-padded, and tagged with a beat count. It sits between narrow streaming producers (DMA read ports, activation fetch) and the wide accelerator datapath. A separate assembly register and output register allow one output word per RATIO input cycles with no bubbles.

## Interface
- IN_WIDTH, 128, input beat width in bits (>=8)
- RATIO, 2, input beats per output word (>=2); OUT_WIDTH = IN_WIDTH*RATIO
- MSB_FIRST, 1, 1: first beat lands in the most-significant slice; 0: first beat lands in slice 0 (LSBs)
- Derived CNT_W = $clog2(RATIO+1)

Ports:
- clock  in  1  clock, rising-edge
- reset  in  1  reset, asynchronous, active-high
- st_in_data  in  IN_WIDTH  input beat
- st_in_valid  in  1  input beat valid
- st_in_endofpacket  in  1  last beat of packet; forces flush of the current word
- st_in_ready  out  1  input may be accepted this cycle
- st_out_data  out  OUT_WIDTH  packed word (registered)
- st_out_valid  out  1  output word held
- st_out_endofpacket  out  1  word closes a packet
- st_out_count  out  CNT_W  number of valid input slices in word (1..RATIO)
- st_out_ready  in  1  downstream accepts

## Operation
- State: beat counter cnt (0..RATIO-1), assembly register asm (OUT_WIDTH), output register plus out_full flag.
- Slice k occupies bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH].
- The beat accepted at count cnt writes slice RATIO-1-cnt when MSB_FIRST=1, else slice cnt.
- Accept = st_in_valid && st_in_ready.
- st_in_ready = !reset && (!out_full || st_out_ready). There is no combinational path from st_in_valid or st_in_endofpacket.
- Accept, not completing (cnt < RATIO-1 and !endofpacket): write slice into asm; cnt <= cnt+1.
- Accept, completing (cnt == RATIO-1 or endofpacket):
  - st_out_data <= asm with the current beat merged; unfilled slices are 0.
  - st_out_count <= cnt+1; st_out_endofpacket <= st_in_endofpacket; out_full <= 1.
  - cnt <= 0; asm <= 0.
- Output handshake (st_out_valid && st_out_ready) with no completing accept in the same cycle: out_full <= 0. st_out_data, st_out_count and st_out_endofpacket hold their old values.
- Simultaneous output handshake and completing accept: out_full stays 1 and the new word replaces the old one. No loss, no bubble.
- Output stalled (out_full && !st_out_ready): st_in_ready = 0, so asm does not fill further. Full-throughput streaming is still guaranteed whenever st_out_ready is held high.
- st_out_valid = out_full.
- Non-completing beats with endofpacket=0 never alter the output register.

## Timing
- Reset (async assert, sync-safe release): cnt=0, asm=0, out_full=0.
- Output reset values: st_out_data=0, st_out_valid=0, st_out_endofpacket=0, st_out_count=0. st_in_ready=0 while reset is high, and 1 in the first cycle after release.
- Latency: st_out_valid rises the cycle after the completing beat is accepted.
- Throughput: with st_out_ready=1 and continuous valid input, one output word every RATIO cycles; st_in_ready stays 1 throughout.
- Single-beat packet (endofpacket on the first beat): the word is emitted with count=1 and the other slices zero.
- Reset mid-word: the partial asm is discarded; no output is produced for it.
- st_out_data is stable while st_out_valid=1 and st_out_ready=0.

## Test plan
- RATIO=2, MSB_FIRST=1, ready=1: input 0xA…A then 0xB…B -> one word {A,B} (A in the upper half), count=2, eop=0, valid one cycle after beat 2; st_in_ready never drops.
- RATIO=4, MSB_FIRST=0: beats 1,2,3,4 -> word with slice0=1 through slice3=4. Hold st_out_ready=0 for 5 cycles -> st_in_ready=0, data stable, no beat lost.
- RATIO=4: beats 7,8 with endofpacket on 8 -> word with 7 and 8 placed per MSB_FIRST, remaining slices 0, count=2, eop=1. The next beat starts a fresh word at cnt 0.
- Back-to-back: st_out_ready=1 and 64 random beats at RATIO=2 -> 32 words at one word per 2 cycles, matching the scoreboard. Includes cycles where the handshake and completion coincide.
- Assert reset after 3 beats of a RATIO=4 word -> all outputs return to reset values; after release, 4 new beats yield exactly one word containing only the new data.
- Random st_in_valid/st_out_ready (50% each), random endofpacket, RATIO=3 -> scoreboard matches data, count and eop exactly; no duplicated or dropped words.
